// File: rtl/deint_result_capture_pkg.sv
// Shared types for the dual-slope voltmeter back end: AFE phase codes, capture FSM states
// and the result metadata record.
package deint_result_capture_pkg;

    localparam int unsigned AFE_W   = 2;
    localparam int unsigned RANGE_W = 3;

    // AFE phase encodings driven by the conversion sequencer
    typedef enum logic [AFE_W-1:0] {
        AFE_IDLE        = 2'b00,
        AFE_AUTO_ZERO   = 2'b01,
        AFE_INTEGRATE   = 2'b10,
        AFE_DEINTEGRATE = 2'b11
    } afe_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_CAPTURE
    } cap_state_e;

    // Everything about a result except its magnitude
    typedef struct packed {
        logic               neg;
        logic [RANGE_W-1:0] rng;
        logic               ovr;
    } res_meta_t;

endpackage

// File: rtl/deint_result_capture_sync_2ff.sv
// Multi-flop synchroniser for asynchronous AFE inputs; depth set by STAGES (>= 1).
module deint_result_capture_sync_2ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= '0;
        end else begin
            ff_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                ff_q[i] <= ff_q[i-1];
            end
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/deint_result_capture.sv
// Times the de-integrate phase and presents each conversion result through a one-deep
// valid/ready buffer. Optional saturation tracking is enabled with `define SAT_TRACK_EN.
module deint_result_capture
    import deint_result_capture_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEINT_MAX   = 40000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [AFE_W-1:0]   afe_sel_i,
    input  logic               comp_i,
    input  logic               ref_sign_i,
    input  logic [RANGE_W-1:0] range_sel_i,
`ifdef SAT_TRACK_EN
    input  logic               sat_hi_i,
    input  logic               sat_lo_i,
`endif
    output logic [CNT_W-1:0]   result_o,
    output logic               result_neg_o,
    output logic [RANGE_W-1:0] result_range_o,
    output logic               result_ovr_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic               drop_o,
    output logic               abort_o
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(DEINT_MAX);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEINT_MAX - 1);
    localparam logic [CNT_W-1:0] SYNC_C = CNT_W'(SYNC_STAGES);

    cap_state_e         state_q, state_d;
    afe_sel_e           afe_prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [RANGE_W-1:0] rng_q, rng_d;
    logic               comp_start_q, comp_start_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   cap_val_q, cap_val_d;
    logic               cap_ovr_q, cap_ovr_d;
    logic [CNT_W-1:0]   res_q, res_d;
    res_meta_t          meta_q, meta_d;
    logic               valid_q, valid_d;
    logic               drop_q, drop_d;
    logic               abort_q, abort_d;

    logic comp_s;
    logic in_deint;
    logic entry;
    logic sat_eff;

    deint_result_capture_sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (comp_i),
        .q_o   (comp_s)
    );

    assign in_deint = (afe_sel_i == AFE_DEINTEGRATE);
    assign entry    = in_deint && (afe_prev_q != AFE_DEINTEGRATE);

`ifdef SAT_TRACK_EN
    logic sat_q, sat_d;

    // Sticky saturation seen during integrate; cleared when a new integrate begins
    always_comb begin
        sat_d = sat_q;
        if (afe_sel_i == AFE_INTEGRATE) begin
            if (afe_prev_q != AFE_INTEGRATE) begin
                sat_d = 1'b0;
            end
            if (sat_hi_i || sat_lo_i) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_eff = sat_q;
`else
    assign sat_eff = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sign_d       = sign_q;
        rng_d        = rng_q;
        comp_start_d = comp_start_q;
        pend_d       = pend_q;
        cap_val_d    = cap_val_q;
        cap_ovr_d    = cap_ovr_q;
        res_d        = res_q;
        meta_d       = meta_q;
        valid_d      = valid_q;
        drop_d       = 1'b0;
        abort_d      = 1'b0;

        if (valid_q && result_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (entry || (pend_q && in_deint)) begin
                    state_d      = ST_COUNT;
                    cnt_d        = '0;
                    sign_d       = ref_sign_i;
                    rng_d        = range_sel_i;
                    comp_start_d = comp_s;
                end
            end
            // Zero-cross beats timeout beats abort
            ST_COUNT: begin
                if (comp_s != comp_start_q) begin
                    state_d   = ST_CAPTURE;
                    cap_ovr_d = 1'b0;
                    cap_val_d = (cnt_q >= SYNC_C) ? (cnt_q - SYNC_C) : '0;
                end else if (cnt_q == LAST_C) begin
                    state_d   = ST_CAPTURE;
                    cap_ovr_d = 1'b1;
                    cap_val_d = MAX_C;
                end else if (!in_deint) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_d    = ST_IDLE;
                pend_d     = entry;
                res_d      = sat_eff ? MAX_C : cap_val_q;
                meta_d.neg = sign_q;
                meta_d.rng = rng_q;
                meta_d.ovr = cap_ovr_q | sat_eff;
                valid_d    = 1'b1;
                drop_d     = valid_q && !result_ready_i;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            afe_prev_q   <= AFE_IDLE;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            rng_q        <= '0;
            comp_start_q <= 1'b0;
            pend_q       <= 1'b0;
            cap_val_q    <= '0;
            cap_ovr_q    <= 1'b0;
            res_q        <= '0;
            meta_q       <= '0;
            valid_q      <= 1'b0;
            drop_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            afe_prev_q   <= afe_sel_e'(afe_sel_i);
            cnt_q        <= cnt_d;
            sign_q       <= sign_d;
            rng_q        <= rng_d;
            comp_start_q <= comp_start_d;
            pend_q       <= pend_d;
            cap_val_q    <= cap_val_d;
            cap_ovr_q    <= cap_ovr_d;
            res_q        <= res_d;
            meta_q       <= meta_d;
            valid_q      <= valid_d;
            drop_q       <= drop_d;
            abort_q      <= abort_d;
        end
    end

    assign result_o       = res_q;
    assign result_neg_o   = meta_q.neg;
    assign result_range_o = meta_q.rng;
    assign result_ovr_o   = meta_q.ovr;
    assign result_valid_o = valid_q;
    assign drop_o         = drop_q;
    assign abort_o        = abort_q;

endmodule

// File: tb/tb_deint_result_capture.sv
// Directed bench for deint_result_capture; exercises SAT_TRACK_EN when that macro is defined.
module tb_deint_result_capture;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  afe_sel_i;
    logic        comp_i;
    logic        ref_sign_i;
    logic [2:0]  range_sel_i;
    logic [15:0] result_o;
    logic        result_neg_o;
    logic [2:0]  result_range_o;
    logic        result_ovr_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic        drop_o;
    logic        abort_o;
`ifdef SAT_TRACK_EN
    logic        sat_hi_i;
    logic        sat_lo_i;
`endif

    int n_checks;
    int n_errors;
    int abort_seen;
    int abort_base;
    logic pv;

    deint_result_capture dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .afe_sel_i      (afe_sel_i),
        .comp_i         (comp_i),
        .ref_sign_i     (ref_sign_i),
        .range_sel_i    (range_sel_i),
`ifdef SAT_TRACK_EN
        .sat_hi_i       (sat_hi_i),
        .sat_lo_i       (sat_lo_i),
`endif
        .result_o       (result_o),
        .result_neg_o   (result_neg_o),
        .result_range_o (result_range_o),
        .result_ovr_o   (result_ovr_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .drop_o         (drop_o),
        .abort_o        (abort_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (abort_o === 1'b1) abort_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic go_idle();
        afe_sel_i = 2'b00;
        tick(2);
    endtask

    // Enter de-integrate, flip comp m cycles after the entry edge, stop just after the load edge
    task automatic run_conv(input int m, input logic sgn, input logic [2:0] rng,
                            input logic rdy, output logic pre_valid);
        ref_sign_i  = sgn;
        range_sel_i = rng;
        afe_sel_i   = 2'b11;
        tick(1 + m);
        comp_i = ~comp_i;
        tick(3);
        pre_valid      = result_valid_o;
        result_ready_i = rdy;
        tick(1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; abort_seen = 0;
        rst_i = 1'b1; afe_sel_i = 2'b00; comp_i = 1'b0; ref_sign_i = 1'b0;
        range_sel_i = 3'd0; result_ready_i = 1'b1;
`ifdef SAT_TRACK_EN
        sat_hi_i = 1'b0; sat_lo_i = 1'b0;
`endif
        tick(3);
        check("rst_valid", 32'(result_valid_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_flags", {28'd0, result_ovr_o, result_neg_o, drop_o, abort_o}, 32'd0);
        rst_i = 1'b0;
        tick(3);

        // Basic conversion, ready held high
        run_conv(100, 1'b1, 3'd5, 1'b1, pv);
        check("t1_latency", 32'(pv), 32'd0);
        check("t1_valid", 32'(result_valid_o), 32'd1);
        check("t1_result", 32'(result_o), 32'd100);
        check("t1_ovr", 32'(result_ovr_o), 32'd0);
        check("t1_neg", 32'(result_neg_o), 32'd1);
        check("t1_range", 32'(result_range_o), 32'd5);
        tick(1);
        check("t1_valid_1cyc", 32'(result_valid_o), 32'd0);
        go_idle();

        // Comp flips with the entry: count saturates at 0
        ref_sign_i = 1'b0; range_sel_i = 3'd7; afe_sel_i = 2'b11; comp_i = ~comp_i;
        tick(3);
        check("t1b_latency", 32'(result_valid_o), 32'd0);
        tick(1);
        check("t1b_valid", 32'(result_valid_o), 32'd1);
        check("t1b_result_zero", 32'(result_o), 32'd0);
        check("t1b_range", 32'(result_range_o), 32'd7);
        go_idle();

        // Timeout
        abort_base = abort_seen;
        ref_sign_i = 1'b0; range_sel_i = 3'd2; afe_sel_i = 2'b11;
        tick(40001);
        check("t2_not_yet", 32'(result_valid_o), 32'd0);
        tick(1);
        check("t2_valid", 32'(result_valid_o), 32'd1);
        check("t2_result", 32'(result_o), 32'd40000);
        check("t2_ovr", 32'(result_ovr_o), 32'd1);
        check("t2_no_abort", 32'(abort_seen - abort_base), 32'd0);
        go_idle();

        // Abort
        abort_base = abort_seen;
        afe_sel_i = 2'b11;
        tick(50);
        afe_sel_i = 2'b00;
        tick(1);
        check("t3_abort", 32'(abort_o), 32'd1);
        tick(1);
        check("t3_abort_pulse", 32'(abort_o), 32'd0);
        check("t3_abort_count", 32'(abort_seen - abort_base), 32'd1);
        check("t3_valid", 32'(result_valid_o), 32'd0);
        tick(2);

        // Overwrite with ready low
        result_ready_i = 1'b0;
        run_conv(20, 1'b0, 3'd1, 1'b0, pv);
        check("t4_first", 32'(result_o), 32'd20);
        check("t4_first_drop", 32'(drop_o), 32'd0);
        go_idle();
        run_conv(30, 1'b1, 3'd3, 1'b0, pv);
        check("t4_drop", 32'(drop_o), 32'd1);
        check("t4_result", 32'(result_o), 32'd30);
        check("t4_meta", {29'd0, result_neg_o, result_range_o[1:0]}, 32'd7);
        tick(1);
        check("t4_drop_pulse", 32'(drop_o), 32'd0);
        check("t4_hold", {15'd0, result_valid_o, result_o}, 32'h0001_001E);
        result_ready_i = 1'b1;
        tick(1);
        check("t4_drain", 32'(result_valid_o), 32'd0);
        go_idle();

        // Load coincident with transfer
        result_ready_i = 1'b0;
        run_conv(10, 1'b0, 3'd4, 1'b0, pv);
        check("t5_first", 32'(result_o), 32'd10);
        go_idle();
        run_conv(15, 1'b1, 3'd6, 1'b1, pv);
        check("t5_prev_valid", 32'(pv), 32'd1);
        check("t5_no_drop", 32'(drop_o), 32'd0);
        check("t5_valid", 32'(result_valid_o), 32'd1);
        check("t5_result", 32'(result_o), 32'd15);
        result_ready_i = 1'b0;
        go_idle();

        // Reset mid-count with a full buffer
        check("t6_pre_valid", 32'(result_valid_o), 32'd1);
        afe_sel_i = 2'b11;
        tick(20);
        rst_i = 1'b1;
        #1;
        check("t6_rst_valid", 32'(result_valid_o), 32'd0);
        check("t6_rst_result", 32'(result_o), 32'd0);
        check("t6_rst_meta", {27'd0, result_ovr_o, result_neg_o, result_range_o}, 32'd0);
        check("t6_rst_pulses", {30'd0, drop_o, abort_o}, 32'd0);
        afe_sel_i = 2'b00;
        tick(2);
        rst_i = 1'b0;
        tick(3);
        run_conv(25, 1'b1, 3'd6, 1'b1, pv);
        check("t6_after_valid", 32'(result_valid_o), 32'd1);
        check("t6_after_result", 32'(result_o), 32'd25);
        check("t6_after_ovr", 32'(result_ovr_o), 32'd0);
        go_idle();

`ifdef SAT_TRACK_EN
        // Saturation during integrate forces overrange
        afe_sel_i = 2'b10;
        tick(3);
        sat_hi_i = 1'b1;
        tick(1);
        sat_hi_i = 1'b0;
        tick(2);
        go_idle();
        run_conv(40, 1'b0, 3'd0, 1'b1, pv);
        check("sat_ovr", 32'(result_ovr_o), 32'd1);
        check("sat_result", 32'(result_o), 32'd40000);
        go_idle();
        afe_sel_i = 2'b10;
        tick(2);
        go_idle();
        run_conv(40, 1'b0, 3'd0, 1'b1, pv);
        check("sat_cleared_ovr", 32'(result_ovr_o), 32'd0);
        check("sat_cleared_result", 32'(result_o), 32'd40);
        go_idle();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
